// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// Optional two's-complement mode is enabled by defining SEQ_DIV_SIGNED_EN.
module seq_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  acc_q, acc_d;   // dividend shifts out MSB-first, quotient shifts in
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic              dz_q, dz_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  rmd_q, rmd_d;
  logic              dzo_q, dzo_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  dvd_mag, dvs_mag, res_quo, res_rem;
  logic [WIDTH:0]    shifted, sub;
  logic              ge;

  assign shifted = {rem_q, acc_q[WIDTH-1]};
  assign sub     = shifted - {1'b0, dvs_q};
  // Partial remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
  assign ge      = ~sub[WIDTH];

`ifdef SEQ_DIV_SIGNED_EN
  logic qneg_q, qneg_d, rneg_q, rneg_d;

  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign res_quo = dz_q ? '1 : (qneg_q ? -acc_q : acc_q);
  // On divide by zero acc_q still holds |dividend|; re-applying the sign restores it.
  assign res_rem = dz_q ? (rneg_q ? -acc_q : acc_q) : (rneg_q ? -rem_q : rem_q);
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign res_quo = dz_q ? '1 : acc_q;
  assign res_rem = dz_q ? acc_q : rem_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dzo_d   = dzo_q;
    done_d  = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = dvd_mag;
          dvs_d   = dvs_mag;
          rem_d   = '0;
          cnt_d   = '0;
          dz_d    = (divisor == '0);
          state_d = (divisor == '0) ? StFin : StRun;
`ifdef SEQ_DIV_SIGNED_EN
          qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          rneg_d  = dividend[WIDTH-1];
`endif
        end
      end
      StRun: begin
        rem_d = ge ? sub[WIDTH-1:0] : shifted[WIDTH-1:0];
        acc_d = {acc_q[WIDTH-2:0], ge};
        if (cnt_q == CntW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = StFin;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFin: begin
        quo_d   = res_quo;
        rmd_d   = res_rem;
        dzo_d   = dz_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dzo_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dzo_q   <= dzo_d;
      done_q  <= done_d;
`ifdef SEQ_DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dzo_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div at WIDTH=8; signed vectors apply when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_div;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend, divisor;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;

  seq_div #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives start for one edge (edge k), scrambles inputs afterwards, checks done at k+lat.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input int lat, input logic [7:0] eq, input logic [7:0] er,
                        input logic edz);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    chk({tag, "_busy"}, 8'(busy), 8'd1);
    for (int j = 1; j <= lat; j++) begin
      @(posedge clk);
      #1;
      if (j < lat) chk({tag, "_early_done"}, 8'(done), 8'd0);
    end
    chk({tag, "_done"}, 8'(done), 8'd1);
    chk({tag, "_busy_lo"}, 8'(busy), 8'd0);
    chk({tag, "_quo"}, quotient, eq);
    chk({tag, "_rem"}, remainder, er);
    chk({tag, "_dz"}, 8'(div_by_zero), 8'(edz));
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 8'(done), 8'd0);
  endtask

  initial begin
    int nd;
    logic [7:0] ra, rb;
    int qa, qb, mq, mr;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_quo", quotient, 8'd0);
    chk("rst_rem", remainder, 8'd0);
    chk("rst_dz", 8'(div_by_zero), 8'd0);

    // First start sits on the first rising edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    run_op("u100_7", 8'd100, 8'd7, 9, 8'd14, 8'd2, 1'b0);
    run_op("dz55", 8'd55, 8'd0, 1, 8'hFF, 8'd55, 1'b1);
    run_op("small5_9", 8'd5, 8'd9, 9, 8'd0, 8'd5, 1'b0);
`ifdef SEQ_DIV_SIGNED_EN
    run_op("s_m100_7", 8'h9C, 8'd7, 9, 8'hF2, 8'hFE, 1'b0);
    run_op("s_m128_m1", 8'h80, 8'hFF, 9, 8'h80, 8'h00, 1'b0);
    run_op("s_dz_m7", 8'hF9, 8'd0, 1, 8'hFF, 8'hF9, 1'b1);
`else
    run_op("u255_1", 8'd255, 8'd1, 9, 8'd255, 8'd0, 1'b0);
    run_op("u255_255", 8'd255, 8'd255, 9, 8'd1, 8'd0, 1'b0);
    run_op("u254_16", 8'd254, 8'd16, 9, 8'd15, 8'd14, 1'b0);
`endif

    // Start while busy must be ignored.
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dividend = 8'd9;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nd = 0;
    for (int j = 4; j < 9; j++) begin
      @(posedge clk);
      #1;
      nd += int'(done);
    end
    chk("busy_early_done", 8'(nd), 8'd0);
    @(posedge clk);
    #1;
    chk("busy_done", 8'(done), 8'd1);
    chk("busy_quo", quotient, 8'd14);
    chk("busy_rem", remainder, 8'd2);
    nd = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      nd += int'(done);
    end
    chk("busy_no_second_done", 8'(nd), 8'd0);

    // Reset mid-operation: outputs clear immediately, no done, then a clean rerun.
    dividend = 8'd200;
    divisor  = 8'd13;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 8'(busy), 8'd0);
    chk("mid_rst_done", 8'(done), 8'd0);
    chk("mid_rst_quo", quotient, 8'd0);
    chk("mid_rst_rem", remainder, 8'd0);
    chk("mid_rst_dz", 8'(div_by_zero), 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      nd += int'(done);
    end
    chk("mid_rst_no_done", 8'(nd), 8'd0);
`ifdef SEQ_DIV_SIGNED_EN
    run_op("rerun200_13", 8'd200, 8'd13, 9, 8'hFC, 8'hFC, 1'b0);
`else
    run_op("rerun200_13", 8'd200, 8'd13, 9, 8'd15, 8'd5, 1'b0);
`endif

    // Small random sweep against the division identity.
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
`ifdef SEQ_DIV_SIGNED_EN
      qa = int'($signed(ra));
      qb = int'($signed(rb));
`else
      qa = int'(ra);
      qb = int'(rb);
`endif
      mq = qa / qb;
      mr = qa % qb;
      run_op($sformatf("rnd%0d", i), ra, rb, 9, 8'(mq), 8'(mr), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  WIDTH  numerator, captured on accepted start.
REQ-006 SHALL have port divisor  input  WIDTH  denominator, captured on accepted start.
REQ-007 SHALL have port busy  output  1  operation in progress; start ignored while high.
REQ-008 SHALL have port done  output  1  single-cycle pulse, results valid.
REQ-009 SHALL have port quotient  output  WIDTH  registered quotient, held until next done.
REQ-010 SHALL have port remainder  output  WIDTH  registered remainder, held until next done.
REQ-011 SHALL have port div_by_zero  output  1  registered flag for last result, updated with done.

Function
REQ-012 SHALL implement a restoring shift/subtract divider using a WIDTH+1-bit partial-remainder subtract, one quotient bit per cycle, MSB first.
REQ-013 SHALL use FSM states IDLE, RUN, FIN, with IDLE as the reset state.
REQ-014 IDLE: start=1 at edge k SHALL capture operands, set busy=1, and go to RUN (divisor nonzero) or FIN (divisor zero).
REQ-015 RUN SHALL perform the iterations at edges k+1..k+WIDTH using an internal counter, then go to FIN at edge k+WIDTH.
REQ-016 FIN SHALL, at edge k+WIDTH+1, load quotient, remainder and div_by_zero, set done=1 and busy=0, and go to IDLE.
REQ-017 done SHALL return to 0 at the following edge; a new start SHALL be sampled no earlier than edge k+WIDTH+2.
REQ-018 start while busy=1 SHALL be ignored, with no effect on operands, state or counter.
REQ-019 Divide by zero SHALL give quotient all ones, remainder = dividend, div_by_zero=1, done at edge k+1.
REQ-020 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor (unsigned mode).
REQ-021 dividend < divisor SHALL give quotient 0 and remainder = dividend after the full WIDTH-cycle latency (no early exit).
REQ-022 Input changes after capture SHALL NOT affect the result in progress.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and counter=0.
REQ-024 Reset asserted mid-operation SHALL abort the operation without producing a done pulse.
REQ-025 The first start SHALL be accepted at the first rising edge after rst_n deasserts.

Configuration
REQ-026 With macro SEQ_DIV_SIGNED_EN defined, operands and results SHALL be two's complement: magnitudes are divided, the quotient is negated if the operand signs differ, and the remainder takes the sign of the dividend (truncation toward zero); sign fixup occurs in FIN with no added latency.
REQ-027 With SEQ_DIV_SIGNED_EN defined, most-negative / -1 SHALL give quotient = most-negative (wrap) and remainder 0, and divide by zero SHALL give quotient all ones and remainder = dividend.
REQ-028 Without SEQ_DIV_SIGNED_EN, all operands SHALL be treated as unsigned and no sign logic SHALL be synthesised.

Verification (WIDTH=8 unless stated)
REQ-029 Unsigned: start at edge k with dividend=100, divisor=7 -> done=1 exactly at edge k+9, quotient=14, remainder=2, div_by_zero=0, busy low at the same edge.
REQ-030 Divide by zero: dividend=55, divisor=0 -> done at edge k+1, quotient=255, remainder=55, div_by_zero=1.
REQ-031 Busy protection: start 100/7, then pulse start with 9/3 at edge k+3 -> single done at k+9 with 14 r 2; no second done.
REQ-032 Reset mid-operation: start 200/13, drop rst_n at k+4 -> all outputs 0 immediately, no done; the next start 200/13 gives 15 r 5.
REQ-033 Signed (SEQ_DIV_SIGNED_EN): -100/7 -> quotient=-14, remainder=-2; -128/-1 -> quotient=-128, remainder=0; done at k+9.
REQ-034 Randomised sweep: 1000 random operand pairs at WIDTH=32, checked against the reference equation of REQ-020, with results logged to a text file.
